// File: rtl/address_sequencer.sv
// Memory address sequencer: PC/ALU/increment sources plus a multi-beat burst engine.
// Optional ADDR_ALIGN_EN forces PC/ALU loads to STEP alignment and flags dropped bits on misalign_o.
module address_sequencer #(
   parameter int unsigned                ADDR_WIDTH = 32,
   parameter int unsigned                STEP       = 4,
   parameter int unsigned                MAX_BURST  = 16,
   parameter logic [ADDR_WIDTH-1:0]      RESET_ADDR = '0,
   localparam int                        BW         = $clog2(MAX_BURST + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            addr_src_i,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   input  logic [ADDR_WIDTH-1:0] alu_i,
   input  logic                  start_burst_i,
   input  logic [BW-1:0]         burst_len_i,
   input  logic                  burst_dir_i,
   input  logic                  mem_ready_i,
   output logic                  req_ready_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  addr_valid_o,
   output logic                  busy_o,
   output logic [BW-1:0]         beats_left_o,
   output logic                  burst_done_o,
   output logic                  misalign_o
);

   typedef enum logic [1:0] {SRC_NONE, SRC_PC, SRC_ALU, SRC_INCR} address_source_t;
   typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
   logic                    valid_reg, valid_next;
   logic [BW-1:0]           beats_reg, beats_next;
   logic                    done_reg, done_next;
   logic                    dir_reg, dir_next;
   // Set while a one-beat burst sits in SINGLE so its acceptance still pulses burst_done_o.
   logic                    last_reg, last_next;

   address_source_t         src;
   logic                    has_src;
   logic                    accept;
   logic [BW-1:0]           len_sat;
   logic [ADDR_WIDTH-1:0]   step_up, step_dn;
   logic [ADDR_WIDTH-1:0]   raw_addr, load_addr;
   logic                    load_mis;

   assign src         = address_source_t'(addr_src_i);
   assign has_src     = (src != SRC_NONE);
   assign req_ready_o = (state_reg == IDLE) || ((state_reg == SINGLE) && mem_ready_i);
   assign accept      = req_ready_o && has_src;
   assign step_up     = addr_reg + ADDR_WIDTH'(STEP);
   assign step_dn     = addr_reg - ADDR_WIDTH'(STEP);

   always_comb begin
      if (burst_len_i == '0)
         len_sat = BW'(1);
      else if (burst_len_i > BW'(MAX_BURST))
         len_sat = BW'(MAX_BURST);
      else
         len_sat = burst_len_i;
   end

   always_comb begin
      case (src)
         SRC_PC:   raw_addr = pc_i;
         SRC_ALU:  raw_addr = alu_i;
         SRC_INCR: raw_addr = burst_dir_i ? step_dn : step_up;
         default:  raw_addr = addr_reg;
      endcase
   end

`ifdef ADDR_ALIGN_EN
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STEP - 1);
   logic pc_or_alu;
   logic misalign_reg, misalign_next;

   assign pc_or_alu = (src == SRC_PC) || (src == SRC_ALU);
   assign load_addr = pc_or_alu ? (raw_addr & ~ALIGN_MASK) : raw_addr;
   assign load_mis  = pc_or_alu && (|(raw_addr & ALIGN_MASK));

   // Flag follows every address update; burst steps from an aligned base never misalign.
   always_comb begin
      misalign_next = misalign_reg;
      if (accept)
         misalign_next = load_mis;
      else if ((state_reg == BURST) && mem_ready_i && valid_reg)
         misalign_next = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         misalign_reg <= 1'b0;
      else
         misalign_reg <= misalign_next;
   end

   assign misalign_o = misalign_reg;
`else
   assign load_addr  = raw_addr;
   assign load_mis   = 1'b0;
   assign misalign_o = load_mis;
`endif

   // State and datapath register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         addr_reg  <= RESET_ADDR;
         valid_reg <= 1'b0;
         beats_reg <= '0;
         done_reg  <= 1'b0;
         dir_reg   <= 1'b0;
         last_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         valid_reg <= valid_next;
         beats_reg <= beats_next;
         done_reg  <= done_next;
         dir_reg   <= dir_next;
         last_reg  <= last_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, SINGLE: begin
            if (accept)
               state_next = (start_burst_i && (len_sat > BW'(1))) ? BURST : SINGLE;
            else if ((state_reg == SINGLE) && mem_ready_i)
               state_next = IDLE;
         end
         BURST: begin
            if (mem_ready_i && valid_reg && (beats_reg == '0))
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath / output next values
   always_comb begin
      addr_next  = addr_reg;
      valid_next = valid_reg;
      beats_next = beats_reg;
      done_next  = 1'b0;
      dir_next   = dir_reg;
      last_next  = last_reg;

      if ((state_reg == SINGLE) && mem_ready_i) begin
         done_next = last_reg;
         if (!accept) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
         end
      end

      if (accept) begin
         addr_next  = load_addr;
         valid_next = 1'b1;
         dir_next   = burst_dir_i;
         if (start_burst_i) begin
            beats_next = len_sat - BW'(1);
            last_next  = (len_sat == BW'(1));
         end else begin
            beats_next = '0;
            last_next  = 1'b0;
         end
      end else if ((state_reg == BURST) && mem_ready_i && valid_reg) begin
         if (beats_reg != '0) begin
            addr_next  = dir_reg ? step_dn : step_up;
            beats_next = beats_reg - BW'(1);
         end else begin
            done_next  = 1'b1;
            valid_next = 1'b0;
         end
      end
   end

   assign addr_o       = addr_reg;
   assign addr_valid_o = valid_reg;
   assign busy_o       = (state_reg != IDLE);
   assign beats_left_o = beats_reg;
   assign burst_done_o = done_reg;

endmodule

// File: tb/tb_address_sequencer.sv
// Directed testbench for address_sequencer (default parameters, 32-bit, STEP=4, MAX_BURST=16).
module tb_address_sequencer;

   localparam int AW = 32;
   localparam int BW = 5;
   localparam logic [1:0] S_NONE = 2'd0, S_PC = 2'd1, S_ALU = 2'd2, S_INCR = 2'd3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    addr_src_i = S_NONE;
   logic [AW-1:0] pc_i = '0;
   logic [AW-1:0] alu_i = '0;
   logic          start_burst_i = 1'b0;
   logic [BW-1:0] burst_len_i = '0;
   logic          burst_dir_i = 1'b0;
   logic          mem_ready_i = 1'b0;
   logic          req_ready_o;
   logic [AW-1:0] addr_o;
   logic          addr_valid_o;
   logic          busy_o;
   logic [BW-1:0] beats_left_o;
   logic          burst_done_o;
   logic          misalign_o;

   int pass_cnt = 0;
   int total_cnt = 0;

   address_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .addr_src_i    (addr_src_i),
      .pc_i          (pc_i),
      .alu_i         (alu_i),
      .start_burst_i (start_burst_i),
      .burst_len_i   (burst_len_i),
      .burst_dir_i   (burst_dir_i),
      .mem_ready_i   (mem_ready_i),
      .req_ready_o   (req_ready_o),
      .addr_o        (addr_o),
      .addr_valid_o  (addr_valid_o),
      .busy_o        (busy_o),
      .beats_left_o  (beats_left_o),
      .burst_done_o  (burst_done_o),
      .misalign_o    (misalign_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      total_cnt++;
      if ({addr_o, addr_valid_o, busy_o, beats_left_o, burst_done_o, misalign_o} !== {32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0})
         $display("FAIL reset_state: addr=%h valid=%b busy=%b beats=%0d done=%b mis=%b, required all zero",
                  addr_o, addr_valid_o, busy_o, beats_left_o, burst_done_o, misalign_o);
      else pass_cnt++;
      reset = 1'b0;
      step();
      total_cnt++;
      if (req_ready_o !== 1'b1) $display("FAIL reset_req_ready: got %b required 1", req_ready_o);
      else pass_cnt++;
      $display("test_reset done");
   endtask

   task automatic test_single_wait();
      addr_src_i = S_PC; pc_i = 32'h100; mem_ready_i = 1'b0;
      step();
      addr_src_i = S_NONE;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (addr_o !== 32'h100 || addr_valid_o !== 1'b1)
            $display("FAIL single_hold[%0d]: addr=%h valid=%b required 00000100/1", i, addr_o, addr_valid_o);
         else pass_cnt++;
         if (i == 3) begin
            mem_ready_i = 1'b1; addr_src_i = S_INCR; burst_dir_i = 1'b0;
            #1;
            total_cnt++;
            if (req_ready_o !== 1'b1) $display("FAIL single_req_ready: got %b required 1", req_ready_o);
            else pass_cnt++;
         end else begin
            total_cnt++;
            if (req_ready_o !== 1'b0) $display("FAIL single_wait_ready: got %b required 0", req_ready_o);
            else pass_cnt++;
         end
         step();
      end
      total_cnt++;
      if (addr_o !== 32'h104 || addr_valid_o !== 1'b1)
         $display("FAIL single_incr: addr=%h valid=%b required 00000104/1", addr_o, addr_valid_o);
      else pass_cnt++;
      addr_src_i = S_NONE;
      step();
      total_cnt++;
      if (addr_valid_o !== 1'b0 || busy_o !== 1'b0 || addr_o !== 32'h104)
         $display("FAIL single_release: valid=%b busy=%b addr=%h required 0/0/00000104", addr_valid_o, busy_o, addr_o);
      else pass_cnt++;
      mem_ready_i = 1'b0;
      $display("test_single_wait done");
   endtask

   task automatic test_burst_asc();
      addr_src_i = S_ALU; alu_i = 32'h2000; start_burst_i = 1'b1; burst_len_i = 5'd4;
      burst_dir_i = 1'b0; mem_ready_i = 1'b1;
      step();
      start_burst_i = 1'b0; addr_src_i = S_PC; pc_i = 32'h500;
      for (int k = 0; k < 4; k++) begin
         total_cnt++;
         if (addr_o !== 32'h2000 + 32'(4 * k) || beats_left_o !== 5'(3 - k) || addr_valid_o !== 1'b1 ||
             req_ready_o !== 1'b0 || burst_done_o !== 1'b0)
            $display("FAIL asc_beat[%0d]: addr=%h beats=%0d valid=%b rdy=%b done=%b required %h/%0d/1/0/0",
                     k, addr_o, beats_left_o, addr_valid_o, req_ready_o, burst_done_o, 32'h2000 + 32'(4 * k), 3 - k);
         else pass_cnt++;
         step();
      end
      total_cnt++;
      if (burst_done_o !== 1'b1 || addr_valid_o !== 1'b0 || addr_o !== 32'h200C || busy_o !== 1'b0)
         $display("FAIL asc_done: done=%b valid=%b addr=%h busy=%b required 1/0/0000200c/0",
                  burst_done_o, addr_valid_o, addr_o, busy_o);
      else pass_cnt++;
      step();
      total_cnt++;
      if (addr_o !== 32'h500 || addr_valid_o !== 1'b1 || burst_done_o !== 1'b0)
         $display("FAIL asc_next_req: addr=%h valid=%b done=%b required 00000500/1/0", addr_o, addr_valid_o, burst_done_o);
      else pass_cnt++;
      addr_src_i = S_NONE;
      step();
      mem_ready_i = 1'b0;
      $display("test_burst_asc done");
   endtask

   task automatic test_burst_desc_wrap();
      logic [AW-1:0] exp_addr [3];
      exp_addr[0] = 32'h4; exp_addr[1] = 32'h0; exp_addr[2] = 32'hFFFF_FFFC;
      addr_src_i = S_ALU; alu_i = 32'h4; start_burst_i = 1'b1; burst_len_i = 5'd3;
      burst_dir_i = 1'b1; mem_ready_i = 1'b1;
      step();
      start_burst_i = 1'b0; addr_src_i = S_NONE; burst_dir_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total_cnt++;
         if (addr_o !== exp_addr[k] || beats_left_o !== 5'(2 - k))
            $display("FAIL desc_beat[%0d]: addr=%h beats=%0d required %h/%0d", k, addr_o, beats_left_o, exp_addr[k], 2 - k);
         else pass_cnt++;
         step();
      end
      total_cnt++;
      if (burst_done_o !== 1'b1 || addr_valid_o !== 1'b0)
         $display("FAIL desc_done: done=%b valid=%b required 1/0", burst_done_o, addr_valid_o);
      else pass_cnt++;
      mem_ready_i = 1'b0;
      step();
      $display("test_burst_desc_wrap done");
   endtask

   task automatic test_len_edges();
      int cnt = 0;
      logic seen = 1'b0;
      logic [AW-1:0] last_addr = '0;
      logic [BW-1:0] first_beats = '0;
      addr_src_i = S_PC; pc_i = 32'h300; start_burst_i = 1'b1; burst_len_i = 5'd0; burst_dir_i = 1'b0;
      step();
      total_cnt++;
      if (addr_o !== 32'h300 || addr_valid_o !== 1'b1 || busy_o !== 1'b1 || beats_left_o !== 5'd0 || burst_done_o !== 1'b0)
         $display("FAIL len0_load: addr=%h valid=%b busy=%b beats=%0d done=%b required 00000300/1/1/0/0",
                  addr_o, addr_valid_o, busy_o, beats_left_o, burst_done_o);
      else pass_cnt++;
      start_burst_i = 1'b0; addr_src_i = S_NONE; mem_ready_i = 1'b1;
      step();
      total_cnt++;
      if (burst_done_o !== 1'b1 || busy_o !== 1'b0 || addr_valid_o !== 1'b0)
         $display("FAIL len0_done: done=%b busy=%b valid=%b required 1/0/0", burst_done_o, busy_o, addr_valid_o);
      else pass_cnt++;
      addr_src_i = S_INCR; start_burst_i = 1'b1; burst_len_i = 5'd31;
      for (int c = 0; c < 40; c++) begin
         step();
         if (c == 0) begin
            first_beats = beats_left_o;
            start_burst_i = 1'b0; addr_src_i = S_NONE;
         end
         if (addr_valid_o) begin
            cnt++;
            last_addr = addr_o;
         end
         if (burst_done_o) begin
            seen = 1'b1;
            break;
         end
      end
      total_cnt++;
      if (!seen) $display("FAIL len31_timeout: done seen=%b required 1 within 40 cycles", seen);
      else pass_cnt++;
      total_cnt++;
      if (cnt != 16 || last_addr !== 32'h340 || first_beats !== 5'd15)
         $display("FAIL len31_beats: beats=%0d last=%h first_left=%0d required 16/00000340/15", cnt, last_addr, first_beats);
      else pass_cnt++;
      mem_ready_i = 1'b0;
      step();
      $display("test_len_edges done");
   endtask

   task automatic test_back_to_back();
      addr_src_i = S_NONE; start_burst_i = 1'b1; burst_len_i = 5'd4; mem_ready_i = 1'b1;
      step();
      total_cnt++;
      if (busy_o !== 1'b0 || addr_valid_o !== 1'b0)
         $display("FAIL none_start: busy=%b valid=%b required 0/0", busy_o, addr_valid_o);
      else pass_cnt++;
      start_burst_i = 1'b0; addr_src_i = S_ALU; alu_i = 32'h10;
      step();
      alu_i = 32'h20;
      #1;
      total_cnt++;
      if (addr_o !== 32'h10 || req_ready_o !== 1'b1)
         $display("FAIL b2b_first: addr=%h rdy=%b required 00000010/1", addr_o, req_ready_o);
      else pass_cnt++;
      step();
      total_cnt++;
      if (addr_o !== 32'h20 || addr_valid_o !== 1'b1)
         $display("FAIL b2b_second: addr=%h valid=%b required 00000020/1", addr_o, addr_valid_o);
      else pass_cnt++;
      addr_src_i = S_NONE;
      step();
      total_cnt++;
      if (addr_valid_o !== 1'b0 || busy_o !== 1'b0)
         $display("FAIL b2b_idle: valid=%b busy=%b required 0/0", addr_valid_o, busy_o);
      else pass_cnt++;
      mem_ready_i = 1'b0;
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid_burst();
      addr_src_i = S_ALU; alu_i = 32'h8000; start_burst_i = 1'b1; burst_len_i = 5'd8;
      burst_dir_i = 1'b0; mem_ready_i = 1'b1;
      step();
      start_burst_i = 1'b0; addr_src_i = S_NONE;
      step();
      step();
      total_cnt++;
      if (addr_o !== 32'h8008 || beats_left_o !== 5'd5)
         $display("FAIL mid_pre_reset: addr=%h beats=%0d required 00008008/5", addr_o, beats_left_o);
      else pass_cnt++;
      reset = 1'b1;
      #1;
      total_cnt++;
      if (addr_o !== 32'h0 || addr_valid_o !== 1'b0 || busy_o !== 1'b0 || beats_left_o !== 5'd0 || burst_done_o !== 1'b0)
         $display("FAIL mid_reset: addr=%h valid=%b busy=%b beats=%0d done=%b required 0/0/0/0/0",
                  addr_o, addr_valid_o, busy_o, beats_left_o, burst_done_o);
      else pass_cnt++;
      step();
      reset = 1'b0; mem_ready_i = 1'b0;
      step();
      total_cnt++;
      if (burst_done_o !== 1'b0 || addr_valid_o !== 1'b0)
         $display("FAIL mid_after: done=%b valid=%b required 0/0", burst_done_o, addr_valid_o);
      else pass_cnt++;
      $display("test_reset_mid_burst done");
   endtask

   task automatic test_align();
      logic [AW-1:0] exp_load, exp_incr;
      logic          exp_mis;
`ifdef ADDR_ALIGN_EN
      exp_load = 32'h100; exp_incr = 32'h104; exp_mis = 1'b1;
`else
      exp_load = 32'h103; exp_incr = 32'h107; exp_mis = 1'b0;
`endif
      addr_src_i = S_PC; pc_i = 32'h103; mem_ready_i = 1'b0;
      step();
      total_cnt++;
      if (addr_o !== exp_load || misalign_o !== exp_mis)
         $display("FAIL align_load: addr=%h mis=%b required %h/%b", addr_o, misalign_o, exp_load, exp_mis);
      else pass_cnt++;
      addr_src_i = S_INCR; burst_dir_i = 1'b0; mem_ready_i = 1'b1;
      step();
      total_cnt++;
      if (addr_o !== exp_incr || misalign_o !== 1'b0)
         $display("FAIL align_incr: addr=%h mis=%b required %h/0", addr_o, misalign_o, exp_incr);
      else pass_cnt++;
      addr_src_i = S_NONE;
      step();
      mem_ready_i = 1'b0;
      $display("test_align done");
   endtask

   initial begin
      test_reset();
      test_single_wait();
      test_burst_asc();
      test_burst_desc_wrap();
      test_len_edges();
      test_back_to_back();
      test_reset_mid_burst();
      test_align();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/address_sequencer.md
Name: address_sequencer

Overview:
- Parametrised successor to the CPU address module; drives the memory address bus.
- Sources, in priority order: PC, ALU result, auto-increment/decrement, plus a multi-beat burst engine for LDM/STM-style transfers.
- Sits between the control decoder (addr_bus_src field) and the memory interface.
- Holds each address until the memory handshake accepts it.

Parameters:
- ADDR_WIDTH, 32, address bus width in bits.
- STEP, 4, byte stride per increment/decrement (power of two, >= 1).
- MAX_BURST, 16, maximum beats per burst; BW = $clog2(MAX_BURST+1).
- RESET_ADDR, 0, value of addr_o after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr_src_i  input  2  0=NONE, 1=PC, 2=ALU, 3=INCR (address_source_t encoding).
- pc_i  input  ADDR_WIDTH  PC value.
- alu_i  input  ADDR_WIDTH  ALU result.
- start_burst_i  input  1  begin a burst, with base taken from addr_src_i.
- burst_len_i  input  BW  number of beats; 0 is treated as 1; values above MAX_BURST saturate to MAX_BURST.
- burst_dir_i  input  1  0=ascending (+STEP), 1=descending (-STEP).
- mem_ready_i  input  1  memory accepted the current address this cycle.
- req_ready_o  output  1  combinational: a new request on addr_src_i/start_burst_i is accepted this cycle.
- addr_o  output  ADDR_WIDTH  registered address.
- addr_valid_o  output  1  addr_o is a live request.
- busy_o  output  1  state != IDLE.
- beats_left_o  output  BW  beats remaining after the current one.
- burst_done_o  output  1  one-cycle pulse when the final burst beat is accepted.
- misalign_o  output  1  see Optional Feature.

Behaviour:
- Reset (async, immediate):
  - addr_o=RESET_ADDR; addr_valid_o=0; beats_left_o=0; burst_done_o=0; misalign_o=0; state=IDLE.
- States: IDLE, SINGLE, BURST.
- req_ready_o = (IDLE) | (SINGLE & mem_ready_i). Always 0 in BURST.
- New address on an accepted request, registered, 1-cycle latency:
  - PC → pc_i.
  - ALU → alu_i.
  - INCR → addr_o+STEP (or −STEP if burst_dir_i=1), using the held addr_o even when addr_valid_o=0.
  - NONE with no start → no load.
- Arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent (0xFFFFFFFC+4 → 0x0).
- IDLE:
  - Accepted non-NONE source, no start → load; addr_valid_o=1; go to SINGLE.
  - start_burst_i with source PC/ALU/INCR → load base; beats_left_o=N−1.
    - N=1 → go to SINGLE, but burst_done_o pulses on its acceptance.
    - N>1 → go to BURST.
  - start_burst_i with source NONE → ignored.
- SINGLE:
  - Hold addr_o while mem_ready_i=0.
  - On mem_ready_i with a new request → load back-to-back; addr_valid_o stays 1.
  - On mem_ready_i with no request → addr_valid_o=0; go to IDLE.
- BURST:
  - addr_src_i and start_burst_i are ignored.
  - On each mem_ready_i: if beats_left_o>0 → addr_o ±= STEP, beats_left_o−−.
  - If beats_left_o==0 → burst_done_o=1 for one cycle, addr_valid_o=0, go to IDLE.
  - No back-to-back request on the final beat; the next request is accepted in the following cycle.
- mem_ready_i while addr_valid_o=0 → ignored.
- Reset asserted mid-burst → abort immediately to reset values; no burst_done_o pulse.

Optional Feature:
- Macro: ADDR_ALIGN_EN.
- Defined:
  - PC/ALU loads force the low log2(STEP) bits to 0.
  - misalign_o is registered alongside addr_o: 1 for the cycle(s) the loaded address is held if any dropped bit was 1.
  - misalign_o clears on the next load.
- Undefined:
  - Addresses pass unmodified.
  - misalign_o is tied to 0.

Test Plan:
- Reset mid-burst: assert reset after beat 2 of 8 → next edge addr_o=RESET_ADDR, addr_valid_o=0, busy_o=0, no burst_done_o.
- Single PC fetch with wait: addr_src=PC, pc_i=0x100; hold mem_ready_i=0 for 3 cycles, then 1 with addr_src=INCR
  → addr_o=0x100 held 4 cycles, then 0x104, addr_valid_o continuous.
- Ascending burst: start, ALU base 0x2000, len=4, mem_ready_i always 1
  → addr_o=0x2000, 0x2004, 0x2008, 0x200C; burst_done_o pulses with 0x200C; req_ready_o=0 throughout.
- Descending burst with wrap: base 0x4, len=3, dir=1 → addr_o=0x4, 0x0, 0xFFFFFFFC; beats_left_o=2, 1, 0.
- Length edge cases: burst_len_i=0 → one beat and a burst_done_o pulse; burst_len_i=31 with MAX_BURST=16 → exactly 16 beats.
- ADDR_ALIGN_EN: pc_i=0x103 → addr_o=0x100, misalign_o=1. Without the macro → addr_o=0x103, misalign_o=0.
